// File: rtl/pe_data_mem_responder_if.sv
// Load/store bus between the PE controller and its data-memory responder.
// Requests are level-held until mem_ack; responses are registered.
interface pe_data_mem_responder_if;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        mem_busy;
    logic        mem_err;

    modport master (
        output mem_read, mem_write, mem_address, mem_funct3, mem_wdata,
        input  mem_ack, mem_rdata, mem_busy, mem_err
    );

    modport slave (
        input  mem_read, mem_write, mem_address, mem_funct3, mem_wdata,
        output mem_ack, mem_rdata, mem_busy, mem_err
    );
endinterface

// File: rtl/pe_data_mem_responder.sv
// PE tile data RAM responder: byte/half/word lanes, RV32I load extension.
// Optional DMEM_MISALIGN_CHECK_EN flags misaligned/illegal accesses on mem_err.
module pe_data_mem_responder #(
    parameter int DEPTH       = 256,
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 1
) (
    input logic                    clk,
    input logic                    reset,
    pe_data_mem_responder_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK,
        S_RELEASE
    } state_e;

    state_e              state_q;
    logic [3:0]          cnt_q;
    logic [ADDR_W+1:0]   addr_q;
    logic [2:0]          f3_q;
    logic [31:0]         wdata_q;
    logic                wr_q;
    logic                ack_q;
    logic                busy_q;
    logic                err_q;
    logic [31:0]         rdata_q;

    logic [31:0]         mem_q [DEPTH];

    logic [31:0]         word_d;
    logic [7:0]          byte_d;
    logic [15:0]         half_d;
    logic [31:0]         rdata_d;
    logic [31:0]         wword_d;
    logic                we_d;
    logic                err_d;

    logic                unused_addr;
    assign unused_addr = ^bus.mem_address[31:ADDR_W+2];

`ifdef DMEM_MISALIGN_CHECK_EN
    logic illegal_d;
    logic misal_d;
    assign illegal_d = wr_q ? (f3_q > 3'b010)
                            : (f3_q == 3'b011 || f3_q[2:1] == 2'b11);
    assign misal_d = (f3_q[1:0] == 2'b01 && addr_q[0])
                  || (f3_q[1:0] == 2'b10 && addr_q[1:0] != 2'b00);
`endif

    always_comb begin
        word_d  = mem_q[addr_q[ADDR_W+1:2]];
        byte_d  = word_d[{addr_q[1:0], 3'b000} +: 8];
        half_d  = word_d[{addr_q[1], 4'b0000} +: 16];
        rdata_d = '0;
        wword_d = word_d;
        we_d    = 1'b0;
        err_d   = 1'b0;
        if (wr_q) begin
            unique case (f3_q)
                3'b000: begin
                    wword_d[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
                    we_d = 1'b1;
                end
                3'b001: begin
                    wword_d[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
                    we_d = 1'b1;
                end
                3'b010: begin
                    wword_d = wdata_q;
                    we_d    = 1'b1;
                end
                default: we_d = 1'b0;
            endcase
        end else begin
            unique case (f3_q)
                3'b000:  rdata_d = {{24{byte_d[7]}}, byte_d};
                3'b001:  rdata_d = {{16{half_d[15]}}, half_d};
                3'b010:  rdata_d = word_d;
                3'b100:  rdata_d = {24'b0, byte_d};
                3'b101:  rdata_d = {16'b0, half_d};
                default: rdata_d = '0;
            endcase
        end
`ifdef DMEM_MISALIGN_CHECK_EN
        if (illegal_d || misal_d) begin
            err_d   = 1'b1;
            we_d    = 1'b0;
            rdata_d = '0;
        end
`endif
    end

    // RAM is not reset; a reset forces IDLE so a pending store never lands.
    always_ff @(posedge clk) begin
        if (state_q == S_ACK && we_d) begin
            mem_q[addr_q[ADDR_W+1:2]] <= wword_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            f3_q    <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            ack_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (bus.mem_read || bus.mem_write) begin
                        addr_q  <= bus.mem_address[ADDR_W+1:0];
                        f3_q    <= bus.mem_funct3;
                        wdata_q <= bus.mem_wdata;
                        wr_q    <= bus.mem_write;
                        busy_q  <= 1'b1;
                        cnt_q   <= 4'(WAIT_STATES - 1);
                        state_q <= (WAIT_STATES == 0) ? S_ACK : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= S_ACK;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_ACK: begin
                    ack_q   <= 1'b1;
                    busy_q  <= 1'b0;
                    rdata_q <= rdata_d;
                    err_q   <= err_d;
                    state_q <= S_RELEASE;
                end
                // Return-to-zero: a held request must drop before re-arming.
                S_RELEASE: begin
                    if (!bus.mem_read && !bus.mem_write) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.mem_ack   = ack_q;
    assign bus.mem_rdata = rdata_q;
    assign bus.mem_busy  = busy_q;
    assign bus.mem_err   = err_q;
endmodule

// File: tb/tb_pe_data_mem_responder.sv
// Randomized bench for pe_data_mem_responder against a byte-array memory model.
// Honours DMEM_MISALIGN_CHECK_EN when computing expected err/data.
module tb_pe_data_mem_responder;
    localparam int DEPTH = 256;
    localparam int WS    = 1;
    localparam int NB    = DEPTH * 4;
`ifdef DMEM_MISALIGN_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    logic [7:0] rm [NB];

    pe_data_mem_responder_if bus ();

    pe_data_mem_responder #(
        .DEPTH      (DEPTH),
        .ADDR_W     (8),
        .WAIT_STATES(WS)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_err(input logic [31:0] addr,
                                   input logic [2:0] f3, input bit wr);
        bit illegal;
        bit mis;
        int n;
        n = (f3 == 3'd1 || f3 == 3'd5) ? 2 : (f3 == 3'd2) ? 4 : 1;
        if (wr) illegal = !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
        else    illegal = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        mis = (addr % n) != 0;
        return CHK_EN && (illegal || mis);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] addr,
                                             input logic [2:0] f3);
        int a;
        int ah;
        int aw;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] w;
        a  = int'(addr % NB);
        ah = a - (a % 2);
        aw = a - (a % 4);
        b  = rm[a];
        h  = {rm[ah+1], rm[ah]};
        w  = {rm[aw+3], rm[aw+2], rm[aw+1], rm[aw]};
        if (ref_err(addr, f3, 1'b0)) return 32'h0;
        case (f3)
            3'd0:    return {{24{b[7]}}, b};
            3'd1:    return {{16{h[15]}}, h};
            3'd2:    return w;
            3'd4:    return {24'h0, b};
            3'd5:    return {16'h0, h};
            default: return 32'h0;
        endcase
    endfunction

    function automatic void ref_store(input logic [31:0] addr,
                                      input logic [2:0] f3,
                                      input logic [31:0] wd);
        int a;
        int base;
        int n;
        a = int'(addr % NB);
        if (ref_err(addr, f3, 1'b1)) return;
        n = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : (f3 == 3'd2) ? 4 : 0;
        if (n == 0) return;
        base = a - (a % n);
        for (int i = 0; i < n; i++) rm[base+i] = wd[8*i +: 8];
    endfunction

    task automatic access(input bit wr, input logic [31:0] addr,
                          input logic [2:0] f3, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er);
        bit got;
        got = 1'b0;
        rd  = '0;
        er  = 1'b0;
        @(negedge clk);
        bus.mem_read    = !wr;
        bus.mem_write   = wr;
        bus.mem_address = addr;
        bus.mem_funct3  = f3;
        bus.mem_wdata   = wd;
        for (int k = 0; k < 40 && !got; k++) begin
            @(posedge clk);
            #1;
            if (bus.mem_ack) begin
                got = 1'b1;
                chk("latency", 32'(k), 32'(1 + WS));
                chk("busy_at_ack", {31'b0, bus.mem_busy}, 32'd0);
                rd = bus.mem_rdata;
                er = bus.mem_err;
            end else begin
                chk("busy_pending", {31'b0, bus.mem_busy}, 32'd1);
                bus.mem_address = $urandom;
                bus.mem_funct3  = 3'($urandom);
                bus.mem_wdata   = $urandom;
            end
        end
        if (!got) chk("ack_timeout", 32'd0, 32'd1);
        @(negedge clk);
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        @(posedge clk);
        #1;
        chk("ack_one_cycle", {31'b0, bus.mem_ack}, 32'd0);
    endtask

    task automatic op(input bit wr, input logic [31:0] addr,
                      input logic [2:0] f3, input logic [31:0] wd,
                      input string tag);
        logic [31:0] rd;
        logic        er;
        logic [31:0] exp_d;
        bit          exp_e;
        exp_d = ref_load(addr, f3);
        exp_e = ref_err(addr, f3, wr);
        access(wr, addr, f3, wd, rd, er);
        if (wr) ref_store(addr, f3, wd);
        else chk({tag, "_rdata"}, rd, exp_d);
        chk({tag, "_err"}, {31'b0, er}, {31'b0, exp_e});
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          acks;
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.mem_address = '0;
        bus.mem_funct3  = '0;
        bus.mem_wdata   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack", {31'b0, bus.mem_ack}, 32'd0);
        chk("rst_rdata", bus.mem_rdata, 32'd0);
        chk("rst_busy", {31'b0, bus.mem_busy}, 32'd0);
        chk("rst_err", {31'b0, bus.mem_err}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int w = 0; w < DEPTH; w++) op(1'b1, 32'(w * 4), 3'd2, $urandom, "init");

        access(1'b1, 32'h08, 3'd2, 32'hDEADBEEF, rd, er);
        ref_store(32'h08, 3'd2, 32'hDEADBEEF);
        access(1'b0, 32'h08, 3'd2, 32'h0, rd, er);
        chk("t1_lw", rd, 32'hDEADBEEF);

        access(1'b1, 32'h09, 3'd0, 32'h80, rd, er);
        ref_store(32'h09, 3'd0, 32'h80);
        access(1'b0, 32'h09, 3'd0, 32'h0, rd, er);
        chk("t2_lb", rd, 32'hFFFFFF80);
        access(1'b0, 32'h09, 3'd4, 32'h0, rd, er);
        chk("t2_lbu", rd, 32'h00000080);
        access(1'b0, 32'h08, 3'd2, 32'h0, rd, er);
        chk("t2_lw", rd, 32'hDEAD80EF);

        @(negedge clk);
        bus.mem_read    = 1'b1;
        bus.mem_address = 32'h08;
        bus.mem_funct3  = 3'd2;
        acks = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (bus.mem_ack) acks++;
        end
        chk("t3_held_acks", 32'(acks), 32'd1);
        chk("t3_held_busy", {31'b0, bus.mem_busy}, 32'd0);
        @(negedge clk);
        bus.mem_read = 1'b0;
        @(negedge clk);
        bus.mem_read = 1'b1;
        acks = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (bus.mem_ack) acks++;
        end
        chk("t3_rearm_acks", 32'(acks), 32'd1);
        chk("t3_rearm_rdata", bus.mem_rdata, 32'hDEAD80EF);
        @(negedge clk);
        bus.mem_read = 1'b0;
        @(posedge clk);

        @(negedge clk);
        bus.mem_write   = 1'b1;
        bus.mem_address = 32'h10;
        bus.mem_funct3  = 3'd2;
        bus.mem_wdata   = 32'h12345678;
        @(posedge clk);
        #1;
        chk("t4_busy_wait", {31'b0, bus.mem_busy}, 32'd1);
        @(negedge clk);
        reset         = 1'b1;
        bus.mem_write = 1'b0;
        #1;
        chk("t4_rst_busy", {31'b0, bus.mem_busy}, 32'd0);
        chk("t4_rst_rdata", bus.mem_rdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        acks = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            if (bus.mem_ack) acks++;
        end
        chk("t4_no_ack", 32'(acks), 32'd0);
        op(1'b0, 32'h10, 3'd2, 32'h0, "t4_old");

        op(1'b0, 32'h03, 3'd1, 32'h0, "t5_lh");

        access(1'b1, 32'h400, 3'd2, 32'hA5A5A5A5, rd, er);
        ref_store(32'h400, 3'd2, 32'hA5A5A5A5);
        access(1'b0, 32'h00, 3'd2, 32'h0, rd, er);
        chk("t6_wrap", rd, 32'hA5A5A5A5);

        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = (i % 2 == 0) ? 32'($urandom_range(0, 63)) : $urandom;
            op(1'($urandom), a, 3'($urandom), $urandom, "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
